// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Bundle of the raster-timing signals exchanged between the
//               VGA timing generator and its consumers.
//                 ce          - pixel advance enable (consumer -> generator)
//                 hpos/vpos   - current column / line (10 bit)
//                 hsync/vsync - sync pulses at the configured polarity
//                 display_on  - inside the visible area
//                 line_tick   - one-cycle pulse at the start of each line
//                 frame_tick  - one-cycle pulse at the start of vertical sync
//                 frame_count - frames started since reset, mod 1024
//               master: the timing generator; slave: the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;

  logic       ce;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_tick;
  logic       frame_tick;
  logic [9:0] frame_count;

  modport master (
    input  ce,
    output hpos,
    output vpos,
    output hsync,
    output vsync,
    output display_on,
    output line_tick,
    output frame_tick,
    output frame_count
  );

  modport slave (
    output ce,
    input  hpos,
    input  vpos,
    input  hsync,
    input  vsync,
    input  display_on,
    input  line_tick,
    input  frame_tick,
    input  frame_count
  );

endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parameterised VGA raster timing generator. A 10-bit column
//               and line counter pair walks the H_TOTAL x V_TOTAL raster;
//               two four-state FSMs (active / front porch / sync / back
//               porch) track the horizontal and vertical phases.
//               Every output is a flop: the next value of each output is
//               computed from the next counter/FSM values, so outputs always
//               agree with the hpos/vpos shown in the same cycle.
// Ports       : clk    - pixel clock, rising edge
//               rst_n  - synchronous active-low reset
//               bus    - vga_timing_gen_if.master (ce in, timing outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_timing_gen_if.master   bus
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // The counters are 10 bits wide; a raster that does not fit must not build.
  generate
    if ((c_H_TOTAL > 1024) || (c_V_TOTAL > 1024)) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
    end
  endgenerate

  localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_H_FP_START = 10'(H_DISPLAY);
  localparam logic [9:0] c_H_SY_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] c_H_BP_START = 10'(H_DISPLAY + H_FRONT + H_SYNC);

  localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_V_FP_START = 10'(V_DISPLAY);
  localparam logic [9:0] c_V_SY_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] c_V_BP_START = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  localparam logic       c_SYNC_ON    = (SYNC_POL != 0);

  // Horizontal FSM encoding
  localparam logic [1:0] c_H_ACT = 2'd0;
  localparam logic [1:0] c_H_FP  = 2'd1;
  localparam logic [1:0] c_H_SY  = 2'd2;
  localparam logic [1:0] c_H_BP  = 2'd3;

  // Vertical FSM encoding
  localparam logic [1:0] c_V_ACT = 2'd0;
  localparam logic [1:0] c_V_FP  = 2'd1;
  localparam logic [1:0] c_V_SY  = 2'd2;
  localparam logic [1:0] c_V_BP  = 2'd3;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  logic [9:0] r_hpos;
  logic [9:0] r_vpos;
  logic [1:0] r_h_state;
  logic [1:0] r_v_state;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_display_on;
  logic       r_line_tick;
  logic       r_frame_tick;
  logic [9:0] r_frame_count;

  // Next-state / next-output values
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_hpos_nxt;
  logic [9:0] w_vpos_nxt;
  logic [1:0] w_h_state_nxt;
  logic [1:0] w_v_state_nxt;
  logic       w_hsync_nxt;
  logic       w_vsync_nxt;
  logic       w_display_on_nxt;
  logic       w_line_tick_nxt;
  logic       w_frame_tick_nxt;
  logic [9:0] w_frame_count_nxt;

  // --------------------------------------------------------------------------
  // State register
  // Reset parks the raster on its very last pixel so that the first enabled
  // edge afterwards wraps both counters to (0,0) and starts a fresh frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hpos        <= c_H_LAST;
      r_vpos        <= c_V_LAST;
      r_h_state     <= c_H_BP;
      r_v_state     <= c_V_BP;
      r_hsync       <= ~c_SYNC_ON;
      r_vsync       <= ~c_SYNC_ON;
      r_display_on  <= 1'b0;
      r_line_tick   <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_frame_count <= 10'd0;
    end else begin
      r_hpos        <= w_hpos_nxt;
      r_vpos        <= w_vpos_nxt;
      r_h_state     <= w_h_state_nxt;
      r_v_state     <= w_v_state_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_display_on  <= w_display_on_nxt;
      r_line_tick   <= w_line_tick_nxt;
      r_frame_tick  <= w_frame_tick_nxt;
      r_frame_count <= w_frame_count_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: counters and both phase FSMs
  // Thresholds are tested against the *next* counter value so the FSM state
  // and the counter it describes are registered on the same edge.
  // Threshold tests run from the latest phase backwards, so a zero-width
  // phase (e.g. a front porch of 0) is simply skipped.
  // --------------------------------------------------------------------------
  always_comb begin
    w_h_wrap      = (r_hpos == c_H_LAST);
    w_v_wrap      = (r_vpos == c_V_LAST);
    w_hpos_nxt    = r_hpos;
    w_vpos_nxt    = r_vpos;
    w_h_state_nxt = r_h_state;
    w_v_state_nxt = r_v_state;

    if (bus.ce) begin
      w_hpos_nxt = w_h_wrap ? 10'd0 : (r_hpos + 10'd1);

      if (w_hpos_nxt == c_H_BP_START) begin
        w_h_state_nxt = c_H_BP;
      end else if (w_hpos_nxt == c_H_SY_START) begin
        w_h_state_nxt = c_H_SY;
      end else if (w_hpos_nxt == c_H_FP_START) begin
        w_h_state_nxt = c_H_FP;
      end else if (w_hpos_nxt == 10'd0) begin
        w_h_state_nxt = c_H_ACT;
      end

      // The vertical side only moves on the line wrap.
      if (w_h_wrap) begin
        w_vpos_nxt = w_v_wrap ? 10'd0 : (r_vpos + 10'd1);

        if (w_vpos_nxt == c_V_BP_START) begin
          w_v_state_nxt = c_V_BP;
        end else if (w_vpos_nxt == c_V_SY_START) begin
          w_v_state_nxt = c_V_SY;
        end else if (w_vpos_nxt == c_V_FP_START) begin
          w_v_state_nxt = c_V_FP;
        end else if (w_vpos_nxt == 10'd0) begin
          w_v_state_nxt = c_V_ACT;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: next value of every registered output.
  // With ce low the counters hold, so the level outputs recompute to their
  // current values while both ticks drop to 0.
  // The frame counter counts the frame_tick that was just presented, which
  // places the increment in the cycle following the tick.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hsync_nxt       = (w_h_state_nxt == c_H_SY) ? c_SYNC_ON : ~c_SYNC_ON;
    w_vsync_nxt       = (w_v_state_nxt == c_V_SY) ? c_SYNC_ON : ~c_SYNC_ON;
    w_display_on_nxt  = (w_hpos_nxt < c_H_FP_START) &&
                        (w_vpos_nxt < c_V_FP_START);
    w_line_tick_nxt   = bus.ce && (w_hpos_nxt == 10'd0);
    w_frame_tick_nxt  = bus.ce && (w_hpos_nxt == 10'd0) &&
                        (w_vpos_nxt == c_V_SY_START);
    w_frame_count_nxt = r_frame_tick ? (r_frame_count + 10'd1) : r_frame_count;
  end

  // --------------------------------------------------------------------------
  // Interface outputs: straight from flops
  // --------------------------------------------------------------------------
  assign bus.hpos        = r_hpos;
  assign bus.vpos        = r_vpos;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.display_on  = r_display_on;
  assign bus.line_tick   = r_line_tick;
  assign bus.frame_tick  = r_frame_tick;
  assign bus.frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Two instances share
//               clk/rst_n/ce: index 0 uses the 640x480 defaults, index 1 a
//               tiny 15x4 raster with active-high sync for fast frame runs.
//               A position model (plain raster arithmetic) predicts every
//               output each cycle; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HD  [2] = '{640, 8};
  localparam int HF  [2] = '{16, 2};
  localparam int HS  [2] = '{96, 3};
  localparam int HB  [2] = '{48, 2};
  localparam int VD  [2] = '{480, 1};
  localparam int VF  [2] = '{10, 1};
  localparam int VS  [2] = '{2, 1};
  localparam int VB  [2] = '{33, 1};
  localparam int POL [2] = '{0, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen_if bus0 ();
  vga_timing_gen_if bus1 ();
  assign bus0.ce = ce;
  assign bus1.ce = ce;

  vga_timing_gen u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  vga_timing_gen #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (1), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .SYNC_POL  (1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic [9:0] o_h  [2];
  logic [9:0] o_v  [2];
  logic [9:0] o_fc [2];
  logic       o_hs [2];
  logic       o_vs [2];
  logic       o_de [2];
  logic       o_lt [2];
  logic       o_ft [2];

  assign o_h[0]  = bus0.hpos;        assign o_h[1]  = bus1.hpos;
  assign o_v[0]  = bus0.vpos;        assign o_v[1]  = bus1.vpos;
  assign o_fc[0] = bus0.frame_count; assign o_fc[1] = bus1.frame_count;
  assign o_hs[0] = bus0.hsync;       assign o_hs[1] = bus1.hsync;
  assign o_vs[0] = bus0.vsync;       assign o_vs[1] = bus1.vsync;
  assign o_de[0] = bus0.display_on;  assign o_de[1] = bus1.display_on;
  assign o_lt[0] = bus0.line_tick;   assign o_lt[1] = bus1.line_tick;
  assign o_ft[0] = bus0.frame_tick;  assign o_ft[1] = bus1.frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: raster position, advance flag, frame tick, frame count
  // --------------------------------------------------------------------------
  int mh  [2];
  int mv  [2];
  int mfc [2];
  bit madv [2];
  bit mft  [2];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mh[i]   = HD[i] + HF[i] + HS[i] + HB[i] - 1;
        mv[i]   = VD[i] + VF[i] + VS[i] + VB[i] - 1;
        mfc[i]  = 0;
        madv[i] = 1'b0;
        mft[i]  = 1'b0;
      end else if (m_valid) begin
        if (mft[i]) mfc[i] = (mfc[i] + 1) % 1024;
        if (ce) begin
          mh[i] = (mh[i] + 1) % (HD[i] + HF[i] + HS[i] + HB[i]);
          if (mh[i] == 0) mv[i] = (mv[i] + 1) % (VD[i] + VF[i] + VS[i] + VB[i]);
          madv[i] = 1'b1;
          mft[i]  = (mh[i] == 0) && (mv[i] == VD[i] + VF[i]);
        end else begin
          madv[i] = 1'b0;
          mft[i]  = 1'b0;
        end
      end
    end
    if (!rst_n) m_valid = 1'b1;
  end

  // Compare process: every cycle after the first reset
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        logic e_hs, e_vs, e_de;
        e_de = (mh[i] < HD[i]) && (mv[i] < VD[i]);
        e_hs = ((mh[i] >= HD[i] + HF[i]) && (mh[i] < HD[i] + HF[i] + HS[i])) ?
               (POL[i] != 0) : (POL[i] == 0);
        e_vs = ((mv[i] >= VD[i] + VF[i]) && (mv[i] < VD[i] + VF[i] + VS[i])) ?
               (POL[i] != 0) : (POL[i] == 0);
        chk("hpos",        32'(o_h[i]),  32'(mh[i]));
        chk("vpos",        32'(o_v[i]),  32'(mv[i]));
        chk("display_on",  32'(o_de[i]), 32'(e_de));
        chk("hsync",       32'(o_hs[i]), 32'(e_hs));
        chk("vsync",       32'(o_vs[i]), 32'(e_vs));
        chk("line_tick",   32'(o_lt[i]), 32'(madv[i] && (mh[i] == 0)));
        chk("frame_tick",  32'(o_ft[i]), 32'(mft[i]));
        chk("frame_count", 32'(o_fc[i]), 32'(mfc[i]));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus and directed literal checks
  // --------------------------------------------------------------------------
  initial begin
    int hs_low, hs_first_h, lt_a, lt_b, nt, nlt;
    bit found;

    // Reset state
    rst_n = 1'b0;
    ce    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hpos",   32'(o_h[0]), 32'd799);
    chk("rst_vpos",   32'(o_v[0]), 32'd524);
    chk("rst_hsync",  32'(o_hs[0]), 32'd1);
    chk("rst_vsync",  32'(o_vs[0]), 32'd1);
    chk("rst_de",     32'(o_de[0]), 32'd0);
    chk("rst_lt",     32'(o_lt[0]), 32'd0);
    chk("rst_fc",     32'(o_fc[0]), 32'd0);
    chk("rst_hsync1", 32'(o_hs[1]), 32'd0);
    rst_n = 1'b1;

    // First line of the default raster
    hs_low = 0; hs_first_h = -1; lt_a = -1; lt_b = -1;
    for (int k = 1; k <= 810; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("c1_hpos", 32'(o_h[0]), 32'd0);
        chk("c1_vpos", 32'(o_v[0]), 32'd0);
        chk("c1_de",   32'(o_de[0]), 32'd1);
        chk("c1_lt",   32'(o_lt[0]), 32'd1);
      end
      if (k == 640) begin
        chk("c640_hpos", 32'(o_h[0]), 32'd639);
        chk("c640_de",   32'(o_de[0]), 32'd1);
      end
      if (k == 641) begin
        chk("c641_hpos", 32'(o_h[0]), 32'd640);
        chk("c641_de",   32'(o_de[0]), 32'd0);
      end
      if (k <= 800 && o_hs[0] == 1'b0) begin
        if (hs_first_h < 0) hs_first_h = int'(o_h[0]);
        hs_low++;
      end
      if (o_lt[0]) begin
        if (lt_a < 0) lt_a = k;
        else if (lt_b < 0) lt_b = k;
      end
    end
    chk("hsync_width", 32'(hs_low), 32'd96);
    chk("hsync_start", 32'(hs_first_h), 32'd656);
    chk("line_period", 32'(lt_b - lt_a), 32'd800);

    // Small raster: 1024 frames, frame_count reads 3 and then wraps to 0
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    nt = 0;
    found = 1'b0;
    for (int k = 0; k < 70000 && !found; k++) begin
      @(posedge clk);
      #1;
      if (o_ft[1]) begin
        nt++;
        @(posedge clk);
        #1;
        if (nt == 3)    chk("fc_after_3",    32'(o_fc[1]), 32'd3);
        if (nt == 1023) chk("fc_after_1023", 32'(o_fc[1]), 32'd1023);
        if (nt == 1024) begin
          chk("fc_wrap", 32'(o_fc[1]), 32'd0);
          found = 1'b1;
        end
      end
    end
    if (!found) chk("frame_wrap_timeout", 32'd0, 32'd1);

    // Reset during vertical sync of the small raster
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk);
      #1;
      if (o_v[1] == 10'd2 && o_h[1] == 10'd5) found = 1'b1;
    end
    if (!found) chk("vsync_wait_timeout", 32'd0, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_hpos",  32'(o_h[1]), 32'd14);
    chk("mid_rst_vpos",  32'(o_v[1]), 32'd3);
    chk("mid_rst_vsync", 32'(o_vs[1]), 32'd0);
    chk("mid_rst_ft",    32'(o_ft[1]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_hpos", 32'(o_h[1]), 32'd0);
    chk("post_rst_vpos", 32'(o_v[1]), 32'd0);
    chk("post_rst_fc",   32'(o_fc[1]), 32'd0);

    // ce toggled every cycle for one default line: 1600 cycles per line
    nlt = 0;
    for (int k = 0; k < 1600; k++) begin
      ce = (k % 2 == 1);
      @(posedge clk);
      #1;
      if (o_lt[0]) nlt++;
    end
    chk("half_rate_hpos", 32'(o_h[0]), 32'd0);
    chk("half_rate_vpos", 32'(o_v[0]), 32'd1);
    chk("half_rate_ticks", 32'(nlt), 32'd1);

    // Randomised ce and occasional reset pulses
    for (int k = 0; k < 8000; k++) begin
      ce    = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 699) != 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    ce    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
